carrier_sweep_ctrl: RTL and testbench

Sequences the carrier frequency word fed to the carrier generator's step calculator. It performs single-frequency loads or stepped linear sweeps (up or down, one-shot or looping) with a programmable dwell per frequency. After each change it waits a fixed settle time for the step computation, then issues a one-cycle load strobe to the carrier path. It sits between the register/config interface and the carrier generator in the QAM modulator clock domain.

---
 rtl/carrier_sweep_ctrl_pkg.sv | 13 +
 rtl/sweep_next_freq.sv | 30 +++
 rtl/carrier_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_carrier_sweep_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/carrier_sweep_ctrl_pkg.sv
// Shared types and constants for the carrier frequency sweep controller.
package carrier_sweep_ctrl_pkg;

  localparam int unsigned FREQ_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    NEXT   = 2'd3
  } state_e;

endpackage

// File: rtl/sweep_next_freq.sv
// Next sweep frequency: step toward f_stop by f_inc, clamped at f_stop
// (also catches 16-bit wrap in either direction).
module sweep_next_freq
  import carrier_sweep_ctrl_pkg::*;
(
  input  logic [FREQ_W-1:0] freq,
  input  logic [FREQ_W-1:0] f_start,
  input  logic [FREQ_W-1:0] f_stop,
  input  logic [FREQ_W-1:0] f_inc,
  output logic [FREQ_W-1:0] next_freq_c
);

  logic            up_c;
  logic [FREQ_W:0] sum_c;
  logic [FREQ_W:0] dif_c;

  always_comb begin
    up_c        = (f_stop >= f_start);
    sum_c       = {1'b0, freq} + {1'b0, f_inc};
    dif_c       = {1'b0, freq} - {1'b0, f_inc};
    next_freq_c = f_stop;
    if (up_c) begin
      if (sum_c <= {1'b0, f_stop}) next_freq_c = sum_c[FREQ_W-1:0];
    end else begin
      // dif_c[FREQ_W] set means the subtraction went below zero
      if (!dif_c[FREQ_W] && (dif_c[FREQ_W-1:0] >= f_stop)) next_freq_c = dif_c[FREQ_W-1:0];
    end
  end

endmodule

// File: rtl/carrier_sweep_ctrl.sv
// Carrier frequency sequencer: single loads or stepped sweeps with settle
// time before each step_load strobe and a programmable dwell per frequency.
module carrier_sweep_ctrl
  import carrier_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned DWELL_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_sweep,
  input  logic               loop_en,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FREQ_W-1:0]  freq,
  output logic               step_load,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC) + 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_e              state;
  logic [SET_W-1:0]    settle_cnt;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [DWELL_W-1:0]  dwell_lat;
  logic [FREQ_W-1:0]   start_lat;
  logic [FREQ_W-1:0]   stop_lat;
  logic [FREQ_W-1:0]   inc_lat;
  logic                single_lat;
  logic                loop_lat;
  logic [FREQ_W-1:0]   next_freq_c;
  logic                start_single_c;

  sweep_next_freq u_next (
    .freq        (freq),
    .f_start     (start_lat),
    .f_stop      (stop_lat),
    .f_inc       (inc_lat),
    .next_freq_c (next_freq_c)
  );

  // A zero increment cannot make progress, so it runs as a single load
  assign start_single_c = !mode_sweep || (f_inc == '0);

  // busy is a pure decode of the state flop
  assign busy = (state != IDLE);

  // Sequencer: the step_load cycle is the first of the dwell_lat dwell cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      freq       <= '0;
      step_load  <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      dwell_lat  <= '0;
      start_lat  <= '0;
      stop_lat   <= '0;
      inc_lat    <= '0;
      single_lat <= 1'b0;
      loop_lat   <= 1'b0;
    end else begin
      step_load <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        settle_cnt <= '0;
        dwell_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_lat  <= f_start;
              stop_lat   <= f_stop;
              inc_lat    <= f_inc;
              single_lat <= start_single_c;
              loop_lat   <= loop_en;
              dwell_lat  <= (start_single_c || (dwell == '0)) ? DWELL_W'(1) : dwell;
              freq       <= f_start;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              step_load  <= 1'b1;
              settle_cnt <= '0;
              dwell_cnt  <= '0;
              state      <= DWELL;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          DWELL: begin
            if (dwell_cnt == (dwell_lat - DWELL_W'(1))) begin
              dwell_cnt <= '0;
              if (single_lat || ((freq == stop_lat) && !loop_lat)) begin
                done  <= 1'b1;
                state <= IDLE;
              end else if (freq == stop_lat) begin
                freq  <= start_lat;
                state <= SETTLE;
              end else begin
                state <= NEXT;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end
          NEXT: begin
            freq  <= next_freq_c;
            state <= SETTLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_carrier_sweep_ctrl.sv
// Cycle-accurate check of carrier_sweep_ctrl against a timeline model built
// from the sweep rules (directed cases followed by randomized configs).
module tb_carrier_sweep_ctrl;

  localparam int SC   = 4;
  localparam int DW   = 24;
  localparam int HMAX = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode_sweep = 1'b0;
  logic          loop_en = 1'b0;
  logic [15:0]   f_start = '0;
  logic [15:0]   f_stop = '0;
  logic [15:0]   f_inc = '0;
  logic [DW-1:0] dwell = '0;
  logic [15:0]   freq;
  logic          step_load;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int held_freq = 0;

  int e_freq [HMAX];
  bit e_sl   [HMAX];
  bit e_done [HMAX];
  bit e_busy [HMAX];

  carrier_sweep_ctrl #(.SETTLE_CYC(SC), .DWELL_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode_sweep (mode_sweep),
    .loop_en    (loop_en),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_inc      (f_inc),
    .dwell      (dwell),
    .freq       (freq),
    .step_load  (step_load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // kill_kind: 0 none, 1 abort pulse, 2 rst pulse, both at relative cycle kill_at
  task automatic run_txn(input bit ms, input bit le, input int fs, input int fe,
                         input int fi, input int dw, input int kill_kind,
                         input int kill_at, input bit noise);
    bit single;
    bit up;
    bit fin;
    int d;
    int t;
    int f;
    int h;
    single = !ms || (fi == 0);
    up     = (fe >= fs);
    d      = (single || dw == 0) ? 1 : dw;
    fin    = 1'b0;
    h      = HMAX;
    for (int c = 0; c < HMAX; c++) begin
      e_freq[c] = held_freq;
      e_sl[c]   = 1'b0;
      e_done[c] = 1'b0;
      e_busy[c] = 1'b0;
    end
    // Walk the frequency list; each step's freq becomes visible SC cycles before its strobe
    t = SC + 1;
    f = fs;
    while (!fin && t < HMAX) begin
      for (int c = t - SC; c < HMAX; c++) e_freq[c] = f;
      e_sl[t] = 1'b1;
      if (single || (f == fe && !le)) begin
        fin = 1'b1;
      end else if (f == fe) begin
        t = t + d + SC;
        f = fs;
      end else begin
        f = up ? ((f + fi > fe) ? fe : f + fi) : ((f - fi < fe) ? fe : f - fi);
        t = t + d + 1 + SC;
      end
    end
    if (fin) begin
      if (t + d < HMAX) e_done[t + d] = 1'b1;
      for (int c = 1; c < t + d && c < HMAX; c++) e_busy[c] = 1'b1;
      h = (t + d + 3 < HMAX) ? t + d + 3 : HMAX;
    end else begin
      for (int c = 1; c < HMAX; c++) e_busy[c] = 1'b1;
    end
    if (kill_kind != 0 && kill_at < h) begin
      for (int c = kill_at + 1; c < HMAX; c++) begin
        e_sl[c]   = 1'b0;
        e_done[c] = 1'b0;
        e_busy[c] = 1'b0;
        e_freq[c] = (kill_kind == 2) ? 0 : e_freq[kill_at];
      end
      h = (kill_at + 4 < h) ? kill_at + 4 : h;
    end
    for (int c = 0; c < h; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (c == 0);
      abort = (kill_kind == 1 && c == kill_at);
      rst   = (kill_kind == 2 && c == kill_at);
      if (c == 0) begin
        mode_sweep = ms;
        loop_en    = le;
        f_start    = 16'(fs);
        f_stop     = 16'(fe);
        f_inc      = 16'(fi);
        dwell      = DW'(dw);
      end else if (noise && e_busy[c] && !(kill_kind != 0 && c == kill_at)
                   && $urandom_range(0, 5) == 0) begin
        start      = 1'b1;
        mode_sweep = 1'($urandom_range(0, 1));
        loop_en    = 1'($urandom_range(0, 1));
        f_start    = 16'($urandom_range(0, 65535));
        f_stop     = 16'($urandom_range(0, 65535));
        f_inc      = 16'($urandom_range(0, 65535));
        dwell      = DW'($urandom_range(0, 20));
      end
      @(negedge clk);
      check_eq("step_load", 32'(step_load), 32'(e_sl[c]));
      check_eq("done", 32'(done), 32'(e_done[c]));
      check_eq("busy", 32'(busy), 32'(e_busy[c]));
      check_eq("freq", 32'(freq), 32'(e_freq[c]));
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    held_freq = e_freq[h - 1];
  endtask

  initial begin
    int fs;
    int fe;
    int fi;
    int span;
    int kk;
    int ka;
    bit ms;
    bit le;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_freq", 32'(freq), 32'd0);
    check_eq("rst_step_load", 32'(step_load), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    held_freq = 0;

    run_txn(1'b0, 1'b0, 1000, 0, 0, 7, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 1000, 1250, 100, 10, 0, 0, 1'b1);
    run_txn(1'b1, 1'b1, 500, 200, 150, 3, 1, 29, 1'b1);
    run_txn(1'b1, 1'b0, 65000, 65535, 1000, 2, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 1000, 0, 400, 1, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 10, 30, 10, 0, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 4321, 9000, 0, 5, 0, 0, 1'b1);
    run_txn(1'b1, 1'b0, 777, 777, 50, 3, 0, 0, 1'b0);
    run_txn(1'b1, 1'b1, 777, 777, 50, 2, 1, 20, 1'b0);
    run_txn(1'b1, 1'b0, 3000, 4000, 300, 4, 2, 2, 1'b0);
    run_txn(1'b1, 1'b0, 3000, 4000, 300, 4, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 200, 100, 80, 2, 1, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ms = ($urandom_range(0, 3) != 0);
      le = ($urandom_range(0, 3) == 0);
      fs = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) begin
        fe = fs;
      end else begin
        fe = fs + int'($urandom_range(0, 6000)) - 3000;
        if ($urandom_range(0, 5) == 0) fe = ($urandom_range(0, 1) != 0) ? 65535 : 0;
        fe = (fe < 0) ? 0 : ((fe > 65535) ? 65535 : fe);
      end
      span = (fe > fs) ? fe - fs : fs - fe;
      fi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(span / 6 + 1, span + 500));
      kk = 0;
      ka = 0;
      if (le && ms && fi != 0) begin
        kk = 1;
        ka = int'($urandom_range(5, 150));
      end else if ($urandom_range(0, 3) == 0) begin
        kk = int'($urandom_range(1, 2));
        ka = int'($urandom_range(0, 60));
      end
      run_txn(ms, le, fs, fe, fi, int'($urandom_range(0, 6)), kk, ka, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
